led_pwm_multi: RTL and testbench
================================

# led_pwm_multi

Parametrised multi-channel PWM generator; successor to the fixed 3-channel, 10-bit RGB PWM. It drives CHANNELS LED outputs from one shared period counter with a programmable prescaler. Each channel has a selectable alignment mode: left, right, centre or forced-off. Duty, mode and prescale are double-buffered and take effect only at a period boundary, so outputs are glitch-free. It sits between the register/command front end and the LED pads.

## Interface
- CHANNELS, 3, number of PWM outputs (1..16)
- WIDTH, 10, duty/counter width; period = 2^WIDTH ticks
- PRE_W, 8, prescaler width
- clk  in  1  single clock; everything is on the rising edge
- rst  in  1  reset, synchronous, active-high (one clock; polarity and synchronicity fixed)
- duty  in  CHANNELS*WIDTH  per-channel duty; channel i is at [i*WIDTH +: WIDTH]
- mode  in  2*CHANNELS  per-channel alignment; channel i is at [2i +: 2]
- prescale  in  PRE_W  tick divider; one tick every prescale+1 clocks
- load  in  1  single-cycle strobe; captures duty/mode/prescale into the shadow registers
- pending  out  1  shadow holds values not yet applied
- period_start  out  1  one-cycle pulse, aligned with the first output cycle of a new period
- pwm_out  out  CHANNELS  registered PWM outputs

## Operation
- Mode encodings: LEFT=2'b00, RIGHT=2'b01, CENTER=2'b10, OFF=2'b11.
- Prescaler `pre`:
  - `tick` = (pre == active_prescale).
  - On tick, `pre` returns to 0; otherwise it increments.
- Counter `cnt` (WIDTH bits):
  - Increments on tick and wraps 2^WIDTH-1 -> 0.
  - `wrap` = tick && cnt == 2^WIDTH-1.
- Shadow registers:
  - On `load`: shadow <= inputs and pending <= 1.
  - A later load before the transfer overwrites the shadow (last write wins).
- Transfer:
  - On `wrap` with pending=1: active <= shadow and pending <= 0.
  - If `load` and `wrap` occur in the same cycle, the transfer uses the old shadow. The new values land in the shadow and pending stays 1, so they apply at the following wrap.
- Per-channel high condition, with D = active duty and N = 2^WIDTH:
  - LEFT: cnt < D
  - RIGHT: cnt >= N-D
  - CENTER: lo <= cnt < lo+D, where lo = (N-D)>>1 (floor)
  - OFF: never high
- Exactly D ticks high per period. D=0 gives a constant low output. Maximum duty is N-1; there is no 100% mode.
- The active prescale changes only at transfer, so the period length never changes mid-period.

## Timing
- Reset values (when rst=1 on an edge):
  - cnt, pre, active/shadow duty, mode and prescale, pending: all 0
  - pwm_out, period_start: 0
- With all active values 0 after reset, the outputs stay low until the first load has been transferred at a wrap.
- pwm_out at cycle n+1 is f(cnt(n), active(n)): one register stage.
- period_start goes high in the cycle after the tick where cnt==0 is evaluated. It pulses once per period, one cycle wide, regardless of prescale.
- Latency from load to effect: at most one full period plus one cycle.
- prescale=0: one tick per clock; period = 2^WIDTH clocks.
- In general, period = 2^WIDTH*(prescale+1) clocks.
- Assertion of rst mid-period forces every output low on the next edge. Shadow contents and pending are discarded.

## Structure
- Package `led_pwm_pkg`: mode localparams (LEFT/RIGHT/CENTER/OFF), a `pwm_mode_t` 2-bit typedef, and a helper function for the centre lower bound.
- Sub-module `led_pwm_channel`: one instance per channel via generate.
  - Inputs: cnt, active duty, active mode.
  - Output: registered pwm bit.
- The top level holds the prescaler, counter, shadow/active registers and the pending/period_start logic.

## Test plan
Bench parameters: WIDTH=4, CHANNELS=3, PRE_W=4.
1. Reset, then idle 40 cycles with no load:
   - pwm_out stays 3'b000 and pending stays 0.
   - period_start pulses every 16 clocks.
2. Load duty=5 on all channels, modes LEFT/RIGHT/CENTER, prescale=0. After the next wrap:
   - ch0 high for cnt 0..4, ch1 for cnt 11..15, ch2 for cnt 5..9 (each seen one cycle later at pwm_out).
   - Exactly 5 high cycles per period on every channel.
3. Load duty 0 and duty 15:
   - Duty 0 gives a constant low.
   - Duty 15 in LEFT gives 15 high and 1 low per period; mode OFF with duty 15 gives a constant low.
4. Load asserted in the same cycle as wrap:
   - The old values persist for one more period and pending stays 1.
   - The new values appear after the next wrap, then pending clears.
5. prescale=2, duty=4 LEFT:
   - period_start every 48 clocks.
   - pwm_out high for 12 consecutive clocks per period.
   - A prescale change loaded mid-period takes effect only at the wrap.
6. Assert rst mid-period while the outputs are high:
   - pwm_out and pending are 0 at the next edge.
   - The counter restarts at 0.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// Shared definitions for the multi-channel LED PWM generator.
//   pwm_mode_t : 2-bit per-channel alignment mode
//   LEFT/RIGHT/CENTER/OFF : mode encodings
//   center_lo() : first high count value of a centre-aligned pulse
package led_pwm_pkg;

  typedef logic [1:0] pwm_mode_t;

  localparam pwm_mode_t LEFT   = 2'b00;
  localparam pwm_mode_t RIGHT  = 2'b01;
  localparam pwm_mode_t CENTER = 2'b10;
  localparam pwm_mode_t OFF    = 2'b11;

  // Lower bound of the centred window: floor((N - D) / 2).
  function automatic logic [31:0] center_lo(input logic [31:0] n, input logic [31:0] d);
    return (n - d) >> 1;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM output channel: compares the shared period counter against the
// active duty according to the active alignment mode; output is registered.
//   clk_i, rst_i : clock, synchronous active-high reset
//   cnt_i        : shared period counter
//   duty_i       : active duty (ticks high per period)
//   mode_i       : active alignment mode
//   pwm_o        : registered PWM bit
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic [WIDTH-1:0] duty_i,
  input  pwm_mode_t        mode_i,
  output logic             pwm_o
);

  // Compare in WIDTH+1 bits so N = 2^WIDTH and lo + D are representable.
  localparam logic [WIDTH:0] N = {1'b1, {WIDTH{1'b0}}};

  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] duty_x;
  logic [WIDTH:0] lo;
  logic           pwm_d;
  logic           pwm_q;

  assign cnt_x  = {1'b0, cnt_i};
  assign duty_x = {1'b0, duty_i};
  assign lo     = (WIDTH+1)'(center_lo(32'(N), 32'(duty_x)));

  always_comb begin
    pwm_d = 1'b0;
    case (mode_i)
      LEFT:    pwm_d = (cnt_x < duty_x);
      RIGHT:   pwm_d = (cnt_x >= (N - duty_x));
      CENTER:  pwm_d = (cnt_x >= lo) && (cnt_x < (lo + duty_x));
      default: pwm_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pwm_q <= 1'b0;
    else       pwm_q <= pwm_d;
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/led_pwm_multi.sv
// Multi-channel PWM generator with a shared prescaled period counter and
// double-buffered duty/mode/prescale that apply only at a period boundary.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   duty_i          : per-channel duty, channel i at [i*WIDTH +: WIDTH]
//   mode_i          : per-channel mode, channel i at [2i +: 2]
//   prescale_i      : one tick every prescale+1 clocks
//   load_i          : strobe capturing duty/mode/prescale into the shadow
//   pending_o       : shadow holds values not yet applied
//   period_start_o  : pulse aligned with the first output cycle of a period
//   pwm_out_o       : registered PWM outputs
module led_pwm_multi
  import led_pwm_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 10,
  parameter int PRE_W    = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CHANNELS*WIDTH-1:0] duty_i,
  input  logic [2*CHANNELS-1:0]     mode_i,
  input  logic [PRE_W-1:0]          prescale_i,
  input  logic                      load_i,
  output logic                      pending_o,
  output logic                      period_start_o,
  output logic [CHANNELS-1:0]       pwm_out_o
);

  logic [PRE_W-1:0]          pre_q, pre_d;
  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic [CHANNELS*WIDTH-1:0] sh_duty_q, sh_duty_d, act_duty_q, act_duty_d;
  logic [2*CHANNELS-1:0]     sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
  logic [PRE_W-1:0]          sh_pre_q, sh_pre_d, act_pre_q, act_pre_d;
  logic                      pending_q, pending_d;
  logic                      period_start_q, period_start_d;
  logic                      tick;
  logic                      wrap;
  logic                      xfer;

  assign tick = (pre_q == act_pre_q);
  assign wrap = tick && (cnt_q == '1);
  assign xfer = wrap && pending_q;

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    cnt_d = tick ? cnt_q + 1'b1 : cnt_q;

    // Transfer reads the pre-load shadow, so a load coinciding with a wrap
    // stays pending and applies at the following wrap.
    sh_duty_d  = load_i ? duty_i     : sh_duty_q;
    sh_mode_d  = load_i ? mode_i     : sh_mode_q;
    sh_pre_d   = load_i ? prescale_i : sh_pre_q;
    act_duty_d = xfer ? sh_duty_q : act_duty_q;
    act_mode_d = xfer ? sh_mode_q : act_mode_q;
    act_pre_d  = xfer ? sh_pre_q  : act_pre_q;

    pending_d = pending_q;
    if (load_i)    pending_d = 1'b1;
    else if (wrap) pending_d = 1'b0;

    // First clock of count 0: the following output cycle is the first of the period.
    period_start_d = (cnt_q == '0) && (pre_q == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q          <= '0;
      cnt_q          <= '0;
      sh_duty_q      <= '0;
      sh_mode_q      <= '0;
      sh_pre_q       <= '0;
      act_duty_q     <= '0;
      act_mode_q     <= '0;
      act_pre_q      <= '0;
      pending_q      <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      pre_q          <= pre_d;
      cnt_q          <= cnt_d;
      sh_duty_q      <= sh_duty_d;
      sh_mode_q      <= sh_mode_d;
      sh_pre_q       <= sh_pre_d;
      act_duty_q     <= act_duty_d;
      act_mode_q     <= act_mode_d;
      act_pre_q      <= act_pre_d;
      pending_q      <= pending_d;
      period_start_q <= period_start_d;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    led_pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .cnt_i  (cnt_q),
      .duty_i (act_duty_q[gi*WIDTH +: WIDTH]),
      .mode_i (pwm_mode_t'(act_mode_q[2*gi +: 2])),
      .pwm_o  (pwm_out_o[gi])
    );
  end

  assign pending_o      = pending_q;
  assign period_start_o = period_start_q;

endmodule

// File: tb/tb_led_pwm_multi.sv
module tb_led_pwm_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] duty_r = '0;
  logic [5:0]  mode_r = '0;
  logic [3:0]  pre_r = '0;
  logic        load = 1'b0;
  logic        pending;
  logic        period_start;
  logic [2:0]  pwm_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  led_pwm_multi #(.CHANNELS(3), .WIDTH(4), .PRE_W(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .duty_i         (duty_r),
    .mode_i         (mode_r),
    .prescale_i     (pre_r),
    .load_i         (load),
    .pending_o      (pending),
    .period_start_o (period_start),
    .pwm_out_o      (pwm_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position within the period as a plain clock phase t;
  // count value is t / (prescale+1), the period is 16*(prescale+1) clocks.
  int   m_t;
  int   m_act_duty[3], m_sh_duty[3], m_act_mode[3], m_sh_mode[3];
  int   m_act_ps, m_sh_ps;
  bit   m_pend;
  bit   m_valid = 0;
  logic [2:0] exp_pwm;
  bit   exp_ps;

  function automatic bit ref_high(int c, int d, int m);
    int lo;
    lo = (16 - d) / 2;
    case (m)
      0:       return c < d;
      1:       return c >= 16 - d;
      2:       return (c >= lo) && (c < lo + d);
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    int per, c;
    bit wr;
    if (rst) begin
      m_t = 0; m_pend = 0; m_act_ps = 0; m_sh_ps = 0;
      for (int i = 0; i < 3; i++) begin
        m_act_duty[i] = 0; m_sh_duty[i] = 0; m_act_mode[i] = 0; m_sh_mode[i] = 0;
      end
      exp_pwm = '0; exp_ps = 0; m_valid = 1;
    end else begin
      per = 16 * (m_act_ps + 1);
      c   = m_t / (m_act_ps + 1);
      for (int i = 0; i < 3; i++) exp_pwm[i] = ref_high(c, m_act_duty[i], m_act_mode[i]);
      exp_ps = (m_t == 0);
      wr = (m_t == per - 1);
      if (wr && m_pend) begin
        for (int i = 0; i < 3; i++) begin
          m_act_duty[i] = m_sh_duty[i]; m_act_mode[i] = m_sh_mode[i];
        end
        m_act_ps = m_sh_ps;
        m_pend = 0;
      end
      if (load) begin
        for (int i = 0; i < 3; i++) begin
          m_sh_duty[i] = int'(duty_r[i*4 +: 4]);
          m_sh_mode[i] = int'(mode_r[2*i +: 2]);
        end
        m_sh_ps = int'(pre_r);
        m_pend = 1;
      end
      m_t = wr ? 0 : m_t + 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("pwm_out", 32'(pwm_out), 32'(exp_pwm));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("period_start", 32'(period_start), 32'(exp_ps));
    end
  end

  task automatic do_load(input logic [11:0] d, input logic [5:0] m, input logic [3:0] p);
    duty_r = d; mode_r = m; pre_r = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    $display("load duty=%h mode=%b prescale=%0d", d, m, p);
  endtask

  task automatic wait_start();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_start && k < 400);
    if (!period_start) chk("period_start_timeout", 32'(period_start), 32'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (pending && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("pending_clears", 32'(pending), 32'd0);
  endtask

  task automatic run_period(output int len, output int h0, output int h1, output int h2);
    int k = 0;
    wait_start();
    len = 1; h0 = int'(pwm_out[0]); h1 = int'(pwm_out[1]); h2 = int'(pwm_out[2]);
    forever begin
      @(negedge clk);
      k++;
      if (period_start || k > 400) break;
      len++;
      h0 += int'(pwm_out[0]); h1 += int'(pwm_out[1]); h2 += int'(pwm_out[2]);
    end
    $display("period len=%0d highs=%0d/%0d/%0d", len, h0, h1, h2);
  endtask

  initial begin
    int len, h0, h1, h2, n, k;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: idle after reset
    repeat (40) @(negedge clk);
    run_period(len, h0, h1, h2);
    chk("t1_len", len, 16);
    chk("t1_highs", h0 + h1 + h2, 0);
    chk("t1_pending", 32'(pending), 0);

    // 2: duty 5 LEFT/RIGHT/CENTER
    do_load({4'd5, 4'd5, 4'd5}, 6'b10_01_00, 4'd0);
    chk("t2_pending_set", 32'(pending), 1);
    wait_idle();
    run_period(len, h0, h1, h2);
    chk("t2_len", len, 16);
    chk("t2_h0", h0, 5); chk("t2_h1", h1, 5); chk("t2_h2", h2, 5);

    // 3: duty 0 LEFT, 15 LEFT, 15 OFF
    do_load({4'd15, 4'd15, 4'd0}, 6'b11_00_00, 4'd0);
    wait_idle();
    run_period(len, h0, h1, h2);
    chk("t3_h0", h0, 0); chk("t3_h1", h1, 15); chk("t3_h2", h2, 0);

    // 4: load coinciding with wrap
    k = 0;
    while (m_t != 15 && k < 100) begin @(negedge clk); k++; end
    chk("t4_align", m_t, 15);
    do_load({4'd3, 4'd3, 4'd3}, 6'b00_00_00, 4'd0);
    chk("t4_pending_held", 32'(pending), 1);
    run_period(len, h0, h1, h2);
    chk("t4_old_h0", h0, 0); chk("t4_old_h1", h1, 15); chk("t4_old_h2", h2, 0);
    run_period(len, h0, h1, h2);
    chk("t4_new_h0", h0, 3); chk("t4_new_h1", h1, 3); chk("t4_new_h2", h2, 3);
    chk("t4_pending_clr", 32'(pending), 0);

    // 5: prescale 2, duty 4 LEFT; mid-period prescale change
    do_load({4'd4, 4'd4, 4'd4}, 6'b00_00_00, 4'd2);
    wait_idle();
    run_period(len, h0, h1, h2);
    chk("t5_len", len, 48);
    chk("t5_h0", h0, 12); chk("t5_h2", h2, 12);
    wait_start();
    do_load({4'd4, 4'd4, 4'd4}, 6'b00_00_00, 4'd0);
    n = 1;
    while (!period_start && n < 200) begin @(negedge clk); n++; end
    chk("t5_len_unchanged", n, 48);
    run_period(len, h0, h1, h2);
    chk("t5_new_len", len, 16);
    chk("t5_new_h1", h1, 4);

    // 6: reset mid-period while high
    do_load({4'd8, 4'd8, 4'd8}, 6'b00_00_00, 4'd0);
    wait_idle();
    wait_start();
    @(negedge clk);
    chk("t6_high", 32'(pwm_out), 7);
    do_load({4'd1, 4'd1, 4'd1}, 6'b00_00_00, 4'd0);
    chk("t6_pending_before", 32'(pending), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_pwm_rst", 32'(pwm_out), 0);
    chk("t6_pending_rst", 32'(pending), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_restart", 32'(period_start), 1);
    repeat (20) @(negedge clk);
    chk("t6_stays_low", 32'(pwm_out), 0);

    // randomized loads and resets checked by the model
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 60)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("reset");
      end else begin
        do_load(12'($urandom_range(0, 4095)), 6'($urandom_range(0, 63)),
                4'($urandom_range(0, 2)));
      end
    end
    repeat (150) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
